// File: rtl/rv_memif.sv
// Memory-interface unit: merges the core's fetch and data ports onto one
// valid/ready memory bus with wait states, byte enables and a bus-error timeout.
module rv_memif #(
   parameter int                 DPWIDTH = 32,
   parameter int                 AWIDTH  = 32,
   parameter int                 TIMEOUT = 16,
   parameter logic [DPWIDTH-1:0] ERRDATA = '1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 imem_req,
   input  logic [AWIDTH-1:0]    imem_addr,
   output logic [DPWIDTH-1:0]   imem_rdata,
   output logic                 imem_ack,
   input  logic                 dmem_req,
   input  logic                 dmem_we,
   input  logic [DPWIDTH/8-1:0] dmem_be,
   input  logic [AWIDTH-1:0]    dmem_addr,
   input  logic [DPWIDTH-1:0]   dmem_wdata,
   output logic [DPWIDTH-1:0]   dmem_rdata,
   output logic                 dmem_ack,
   output logic                 stall,
   output logic                 bus_err,
   output logic                 mem_valid,
   output logic                 mem_we,
   output logic [DPWIDTH/8-1:0] mem_be,
   output logic [AWIDTH-1:0]    mem_addr,
   output logic [DPWIDTH-1:0]   mem_wdata,
   input  logic                 mem_ready,
   input  logic [DPWIDTH-1:0]   mem_rdata
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [2:0] {IDLE, IBUS, DBUS, RESP, ERR} state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   assign stall = (imem_req | dmem_req) & ~(imem_ack | dmem_ack);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         imem_rdata <= '0;
         dmem_rdata <= '0;
         imem_ack   <= 1'b0;
         dmem_ack   <= 1'b0;
         bus_err    <= 1'b0;
         mem_valid  <= 1'b0;
         mem_we     <= 1'b0;
         mem_be     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         imem_ack <= 1'b0;
         dmem_ack <= 1'b0;
         bus_err  <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (dmem_req) begin
                  mem_valid <= 1'b1;
                  mem_we    <= dmem_we;
                  mem_be    <= dmem_be;
                  mem_addr  <= dmem_addr;
                  mem_wdata <= dmem_wdata;
                  state     <= DBUS;
               end else if (imem_req) begin
                  mem_valid <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_be    <= '1;
                  mem_addr  <= imem_addr;
                  mem_wdata <= '0;
                  state     <= IBUS;
               end
            end
            IBUS, DBUS: begin
               // mem_ready wins over the timeout on the final allowed cycle
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  mem_we    <= 1'b0;
                  if (state == IBUS) begin
                     imem_rdata <= mem_rdata;
                     imem_ack   <= 1'b1;
                  end else begin
                     if (!mem_we) dmem_rdata <= mem_rdata;
                     dmem_ack <= 1'b1;
                  end
                  state <= RESP;
               end else if (TIMEOUT > 0 && cnt == CNT_LAST) begin
                  mem_valid <= 1'b0;
                  mem_we    <= 1'b0;
                  bus_err   <= 1'b1;
                  if (state == IBUS) begin
                     imem_rdata <= ERRDATA;
                     imem_ack   <= 1'b1;
                  end else begin
                     if (!mem_we) dmem_rdata <= ERRDATA;
                     dmem_ack <= 1'b1;
                  end
                  state <= ERR;
               end else if (TIMEOUT > 0) begin
                  cnt <= cnt + CW'(1);
               end
            end
            RESP: begin
               cnt   <= '0;
               state <= IDLE;
            end
            ERR: begin
               cnt   <= '0;
               state <= IDLE;
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv_memif.sv
// Bench for rv_memif: vector table, randomized transactions against a
// transaction-level model, and hand-written multi-cycle corner cases.
module tb_rv_memif;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, dmem_req, dmem_we, mem_ready;
   logic [31:0] imem_addr, dmem_addr, dmem_wdata, mem_rdata;
   logic [3:0]  dmem_be;

   logic [31:0] a_imem_rdata, a_dmem_rdata, a_mem_addr, a_mem_wdata;
   logic        a_imem_ack, a_dmem_ack, a_stall, a_bus_err, a_mem_valid, a_mem_we;
   logic [3:0]  a_mem_be;
   logic [31:0] b_imem_rdata, b_dmem_rdata, b_mem_addr, b_mem_wdata;
   logic        b_imem_ack, b_dmem_ack, b_stall, b_bus_err, b_mem_valid, b_mem_we;
   logic [3:0]  b_mem_be;

   always #5 clk = ~clk;

   rv_memif #(.DPWIDTH(32), .AWIDTH(32), .TIMEOUT(8)) u_dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(a_imem_rdata), .imem_ack(a_imem_ack),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(a_dmem_rdata), .dmem_ack(a_dmem_ack),
      .stall(a_stall), .bus_err(a_bus_err),
      .mem_valid(a_mem_valid), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   rv_memif #(.DPWIDTH(32), .AWIDTH(32), .TIMEOUT(0)) u_dut_nto (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(b_imem_rdata), .imem_ack(b_imem_ack),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(b_dmem_rdata), .dmem_ack(b_dmem_ack),
      .stall(b_stall), .bus_err(b_bus_err),
      .mem_valid(b_mem_valid), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   int total  = 0;
   int passed = 0;
   logic [31:0] m_irdata, m_drdata;

   typedef struct {
      bit          is_d;
      bit          we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waits;
      int          exp_lat;
      bit          exp_err;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   // Issue one core request, act as the memory with v.waits wait states,
   // and compare latency, bus values, ack/err and read data.
   task automatic run_txn(input vec_t v);
      int   nvalid = 0;
      int   cyc = 0;
      bit   got = 1'b0;
      bit   bus_ok = 1'b1;
      bit   exp_we;
      logic [3:0] exp_be;
      exp_we = v.is_d ? v.we : 1'b0;
      exp_be = v.is_d ? v.be : 4'hF;
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      if (v.is_d) begin
         dmem_req = 1'b1; dmem_we = v.we; dmem_be = v.be;
         dmem_addr = v.addr; dmem_wdata = v.wdata;
      end else begin
         imem_req = 1'b1; imem_addr = v.addr;
      end
      #1 check("stall_on_req", {31'd0, a_stall}, 32'd1);
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (a_imem_ack || a_dmem_ack) begin
            got = 1'b1;
            mem_ready = 1'b0;
            check("ack_latency", cyc, v.exp_lat);
            check("valid_cycles", nvalid, v.exp_lat - 1);
            check("ack_target", {30'd0, a_dmem_ack, a_imem_ack}, v.is_d ? 32'd2 : 32'd1);
            check("bus_err", {31'd0, a_bus_err}, {31'd0, v.exp_err});
            check("rdata", v.is_d ? a_dmem_rdata : a_imem_rdata, v.exp_rd);
            check("stall_at_ack", {31'd0, a_stall}, 32'd0);
            check("bus_stable", {31'd0, bus_ok}, 32'd1);
            imem_req = 1'b0;
            dmem_req = 1'b0;
         end else if (a_mem_valid) begin
            nvalid++;
            if (a_mem_addr !== v.addr || a_mem_we !== exp_we || a_mem_be !== exp_be) bus_ok = 1'b0;
            if (v.is_d && a_mem_wdata !== v.wdata) bus_ok = 1'b0;
            mem_ready = (nvalid == v.waits + 1);
            mem_rdata = v.rdata;
            imem_addr = $urandom; dmem_addr = $urandom; dmem_wdata = $urandom;
            dmem_be = 4'($urandom); dmem_we = 1'($urandom_range(0, 1));
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
         end
      end
      check("ack_seen", {31'd0, got}, 32'd1);
      @(negedge clk);
      check("idle_after_ack", {29'd0, a_mem_valid, a_imem_ack, a_dmem_ack}, 32'd0);
      if (v.is_d) m_drdata = v.exp_rd;
      else m_irdata = v.exp_rd;
   endtask

   initial begin
      vec_t v;
      int   cyc, dcyc, icyc, dn, in_n, nv, errs, acks;
      bit   seen, got, bus_ok;
      logic [31:0] first_addr;

      rst = 1'b1; imem_req = 0; dmem_req = 0; dmem_we = 0; dmem_be = 0;
      imem_addr = 0; dmem_addr = 0; dmem_wdata = 0; mem_ready = 0; mem_rdata = 0;
      repeat (3) @(negedge clk);
      check("rst_valid", {31'd0, a_mem_valid}, 32'd0);
      check("rst_acks_err", {29'd0, a_imem_ack, a_dmem_ack, a_bus_err}, 32'd0);
      check("rst_irdata", a_imem_rdata, 32'd0);
      check("rst_drdata", a_dmem_rdata, 32'd0);
      check("rst_bus", a_mem_addr | a_mem_wdata | {27'd0, a_mem_we, a_mem_be}, 32'd0);
      check("rst_stall", {31'd0, a_stall}, 32'd0);
      check("rst_b_valid", {31'd0, b_mem_valid}, 32'd0);
      rst = 1'b0;
      m_irdata = 0; m_drdata = 0;

      tbl[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'h0050_0093, 0, 2, 1'b0, 32'h0050_0093};
      tbl[1] = '{1'b1, 1'b1, 4'hF, 32'h0000_2000, 32'hDEAD_BEEF, 32'h1111_1111, 3, 5, 1'b0, 32'h0};
      tbl[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_2004, 32'h0, 32'h1234_5678, 0, 2, 1'b0, 32'h1234_5678};
      tbl[3] = '{1'b1, 1'b0, 4'hF, 32'h0000_3000, 32'h0, 32'h5555_5555, 20, 9, 1'b1, 32'hFFFF_FFFF};
      tbl[4] = '{1'b1, 1'b1, 4'h4, 32'h0000_2001, 32'h00AB_0000, 32'h2222_2222, 3, 5, 1'b0, 32'hFFFF_FFFF};
      tbl[5] = '{1'b0, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 32'hA5A5_A5A5, 7, 9, 1'b0, 32'hA5A5_A5A5};
      tbl[6] = '{1'b0, 1'b0, 4'hF, 32'h0000_0204, 32'h0, 32'h3333_3333, 8, 9, 1'b1, 32'hFFFF_FFFF};
      tbl[7] = '{1'b1, 1'b1, 4'h3, 32'h0000_4000, 32'h0BAD_F00D, 32'h4444_4444, 9, 9, 1'b1, 32'hFFFF_FFFF};
      for (int i = 0; i < 8; i++) run_txn(tbl[i]);

      // simultaneous requests: data first, then fetch
      @(negedge clk);
      imem_req = 1'b1; imem_addr = 32'h108;
      dmem_req = 1'b1; dmem_we = 1'b0; dmem_be = 4'hF; dmem_addr = 32'h2004;
      mem_ready = 1'b0;
      cyc = 0; dcyc = 0; icyc = 0; dn = 0; in_n = 0; seen = 0; first_addr = 0;
      while (in_n == 0 && cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (a_dmem_ack) begin
            dn++; dcyc = cyc; dmem_req = 1'b0;
            check("sim_drdata", a_dmem_rdata, 32'h1234_5678);
         end
         if (a_imem_ack) begin
            in_n++; icyc = cyc; imem_req = 1'b0;
            check("sim_irdata", a_imem_rdata, 32'h0000_0013);
         end
         if (a_mem_valid) begin
            if (!seen) first_addr = a_mem_addr;
            seen = 1'b1;
            mem_ready = 1'b1;
            mem_rdata = (a_mem_addr == 32'h2004) ? 32'h1234_5678 : 32'h0000_0013;
         end else mem_ready = 1'b0;
      end
      repeat (3) begin
         @(negedge clk);
         dn += int'(a_dmem_ack); in_n += int'(a_imem_ack);
      end
      check("sim_first_addr", first_addr, 32'h2004);
      check("sim_dack_cycle", dcyc, 2);
      check("sim_iack_cycle", icyc, 5);
      check("sim_dack_count", dn, 1);
      check("sim_iack_count", in_n, 1);
      m_drdata = 32'h1234_5678; m_irdata = 32'h0000_0013;

      // reset during the second wait cycle of a fetch
      @(negedge clk);
      imem_req = 1'b1; imem_addr = 32'h400; mem_ready = 1'b0;
      @(negedge clk);
      check("rstmid_valid1", {31'd0, a_mem_valid}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rstmid_valid_low", {31'd0, a_mem_valid}, 32'd0);
      acks = int'(a_imem_ack) + int'(a_bus_err);
      imem_req = 1'b0; rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         acks += int'(a_imem_ack) + int'(a_bus_err) + int'(a_mem_valid);
      end
      check("rstmid_no_ack", acks, 0);
      m_irdata = 0; m_drdata = 0;
      v = '{1'b0, 1'b0, 4'hF, 32'h104, 32'h0, 32'h0010_0073, 0, 2, 1'b0, 32'h0010_0073};
      run_txn(v);

      // randomized transactions against the transaction-level model
      for (int i = 0; i < 40; i++) begin
         bit err;
         v.is_d  = 1'($urandom_range(0, 1));
         v.we    = 1'($urandom_range(0, 1));
         v.be    = 4'($urandom);
         v.addr  = $urandom;
         v.wdata = $urandom;
         v.rdata = $urandom;
         v.waits = $urandom_range(0, 11);
         err = (v.waits >= 8);
         v.exp_err = err;
         v.exp_lat = (err ? 8 : v.waits + 1) + 1;
         if (v.is_d && v.we) v.exp_rd = m_drdata;
         else v.exp_rd = err ? 32'hFFFF_FFFF : v.rdata;
         run_txn(v);
      end

      // TIMEOUT=0 instance: byte store with 40 wait states
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      dmem_req = 1'b1; dmem_we = 1'b1; dmem_be = 4'h4;
      dmem_addr = 32'h2001; dmem_wdata = 32'h00AB_0000; mem_ready = 1'b0;
      nv = 0; errs = 0; cyc = 0; got = 0; bus_ok = 1'b1;
      while (!got && cyc < 80) begin
         @(negedge clk);
         cyc++;
         errs += int'(b_bus_err);
         if (b_dmem_ack) begin
            got = 1'b1; dmem_req = 1'b0; mem_ready = 1'b0;
         end else if (b_mem_valid) begin
            nv++;
            if (b_mem_be !== 4'h4 || b_mem_addr !== 32'h2001 || b_mem_we !== 1'b1 ||
                b_mem_wdata !== 32'h00AB_0000) bus_ok = 1'b0;
            mem_ready = (nv == 41);
         end else mem_ready = 1'b0;
      end
      check("nto_ack_seen", {31'd0, got}, 32'd1);
      check("nto_valid_cycles", nv, 41);
      check("nto_ack_cycle", cyc, 42);
      check("nto_no_bus_err", errs, 0);
      check("nto_bus_stable", {31'd0, bus_ok}, 32'd1);
      check("nto_drdata_kept", b_dmem_rdata, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/rv_memif.md
Name: rv_memif

Overview:
- Parametrised memory-interface unit for the next-generation multicycle RISC-V core.
- Merges the core's separate instruction-fetch and data-access ports onto one single-ported memory bus with a valid/ready handshake, arbitrary wait states and byte enables.
- Provides a stall indication to the control FSM and a bus-error timeout.
- Sits between the core datapath/control and the external memory model.

Parameters:
- DPWIDTH, 32, data path and memory data width in bits; must be a multiple of 8.
- AWIDTH, 32, address width in bits.
- TIMEOUT, 16, maximum cycles mem_valid is held without mem_ready before abort; 0 disables the timeout.
- ERRDATA, all ones, read data returned on a timed-out access.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_req  in  1  fetch request; held high by the core until imem_ack.
- imem_addr  in  AWIDTH  fetch address.
- imem_rdata  out  DPWIDTH  fetched instruction; valid in the imem_ack cycle.
- imem_ack  out  1  one-cycle fetch completion pulse.
- dmem_req  in  1  data request; held high by the core until dmem_ack.
- dmem_we  in  1  1 = write, 0 = read.
- dmem_be  in  DPWIDTH/8  byte enables for writes.
- dmem_addr  in  AWIDTH  data address.
- dmem_wdata  in  DPWIDTH  write data.
- dmem_rdata  out  DPWIDTH  load data; valid in the dmem_ack cycle.
- dmem_ack  out  1  one-cycle data completion pulse.
- stall  out  1  a core request is pending and not yet acknowledged.
- bus_err  out  1  one-cycle pulse with the ack of a timed-out access.
- mem_valid  out  1  bus request valid.
- mem_we  out  1  bus write strobe.
- mem_be  out  DPWIDTH/8  bus byte enables.
- mem_addr  out  AWIDTH  bus address.
- mem_wdata  out  DPWIDTH  bus write data.
- mem_ready  in  1  memory completes the transfer this cycle.
- mem_rdata  in  DPWIDTH  read data; valid when mem_ready=1.

Behaviour:
- Reset:
  - All outputs 0 (rdata registers cleared); FSM to IDLE; wait counter to 0.
  - Reset mid-transfer abandons the access: mem_valid is low the cycle after rst is sampled, and no ack or bus_err is issued.
- FSM states: IDLE, IBUS, DBUS, RESP, ERR.
- IDLE:
  - dmem_req=1 goes to DBUS; otherwise imem_req=1 goes to IBUS.
  - Data has priority on simultaneous requests.
  - Address, we, be and wdata are latched on this edge.
  - Instruction accesses drive mem_we=0 and mem_be all ones.
- IBUS/DBUS:
  - mem_valid=1 with registered, stable mem_addr/we/be/wdata.
  - Wait counter increments each cycle.
  - mem_ready=1: capture mem_rdata into imem_rdata or dmem_rdata (writes leave dmem_rdata unchanged), go to RESP.
  - If TIMEOUT>0, counter==TIMEOUT-1 and mem_ready=0: go to ERR.
  - mem_ready sampled only while mem_valid=1; ignored elsewhere.
- RESP: pulse the matching ack for one cycle, return to IDLE, clear counter.
- ERR:
  - Pulse the matching ack and bus_err together.
  - The read target receives ERRDATA; writes are dropped.
  - Return to IDLE.
- Latency:
  - Request seen in cycle N gives mem_valid in N+1.
  - mem_ready in cycle M gives ack in M+1.
  - Zero-wait access: ack at N+2.
  - Back-to-back requests: next mem_valid no earlier than ack cycle+1 (IDLE occupies the ack's following cycle).
- stall: combinational (imem_req | dmem_req) & ~(imem_ack | dmem_ack).
- Request dropped mid-transfer (protocol violation): the transfer still completes and the ack still pulses; no new request is taken until IDLE.
- Core inputs changing while the request is held do not affect the in-flight bus signals.
- Counter width: clog2(TIMEOUT+1), minimum 1; no wrap, since it is cleared on exit from IBUS/DBUS.

Test Plan:
- Zero-wait fetch: imem_req, addr 0x100; mem_ready=1 first valid cycle, mem_rdata 0x00500093 -> mem_valid for 1 cycle, mem_be 0xF, mem_we 0; imem_ack at N+2 with imem_rdata 0x00500093; stall high N..N+1.
- Write with 3 wait states: dmem_req, we=1, addr 0x2000, wdata 0xDEADBEEF, be 0xF; mem_ready on 4th valid cycle -> mem_valid/mem_we high 4 cycles with stable bus values; dmem_ack 1 cycle later; bus_err 0.
- Simultaneous requests: imem_req and dmem_req (read 0x2004, data 0x12345678) same cycle -> data access on bus first, dmem_ack; then fetch starts, imem_ack; exactly one ack pulse each, in that order.
- Timeout: TIMEOUT=8, read 0x3000, mem_ready held 0 -> mem_valid exactly 8 cycles, then dmem_ack and bus_err pulse together, dmem_rdata 0xFFFFFFFF, FSM back to IDLE.
- Reset mid-transfer: rst asserted during 2nd wait cycle of a fetch -> mem_valid 0 next cycle, imem_ack never pulses; a new fetch after reset completes normally.
- Byte store: we=1, be 0x4, addr 0x2001, wdata 0x00AB0000 -> mem_be 0x4 on bus; TIMEOUT=0 with 40 wait states -> no bus_err, ack after mem_ready.
